uart_frame_parser: RTL

//  Downstream of the UART receiver. Consumes its byte stream (data byte + 1-cycle valid

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_frame_parser_if.sv | 30 +++
 rtl/uart_frame_buf.sv | 41 ++++
 rtl/uart_frame_parser.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   frame_state_t  : state encoding of the frame parser FSM
//   SofByteDefault : default start-of-frame byte
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StCmd,
        StPayload,
        StCsum,
        StDrain
    } frame_state_t;

    localparam logic [7:0] SofByteDefault = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream interface of the UART frame parser.
//   in_data/in_valid   : received bytes from the UART receiver (no backpressure)
//   out_data/out_valid/out_ready/out_last : payload stream to the host logic
//   out_cmd/out_len    : CMD and LEN of the frame being drained
// Modports: slave = parser side, master = surrounding logic side.
interface uart_frame_parser_if #(
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic [7:0]    in_data;
    logic          in_valid;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [7:0]    out_cmd;
    logic [LW-1:0] out_len;

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_last, out_cmd, out_len
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_last, out_cmd, out_len
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk      : clock
//   wr_en    : write strobe
//   wr_idx   : write index (< MAX_LEN)
//   wr_data  : write byte
//   rd_idx   : read index (< MAX_LEN)
//   rd_data  : byte at rd_idx
module uart_frame_buf #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned IDX_W   = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [MAX_LEN];

    // Full-width index compare per entry, so the index width need not match the depth.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser. Delimits SOF, LEN, CMD, PAYLOAD[LEN], CSUM frames from the UART
// receiver byte stream, checks length and XOR checksum, buffers the payload and releases
// validated frames as a valid/ready byte stream.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : byte-stream interface (slave modport)
//   err_len     : pulse, LEN == 0 or LEN > MAX_LEN
//   err_csum    : pulse, checksum mismatch
//   err_timeout : pulse, partial frame aborted on inter-byte gap
//   err_overrun : pulse, byte dropped while draining
//   busy        : FSM not idle
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE     = SofByteDefault,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 50_000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_frame_parser_if.slave bus,
    output logic               err_len,
    output logic               err_csum,
    output logic               err_timeout,
    output logic               err_overrun,
    output logic               busy
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned GW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [GW-1:0] GapLimit = GW'(TIMEOUT_CLKS - 1);

    frame_state_t  state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    csum_q, csum_d;
    logic [LW-1:0] wr_idx_q, wr_idx_d;
    logic [LW-1:0] rd_idx_q, rd_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          err_len_q, err_len_d;
    logic          err_csum_q, err_csum_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_overrun_q, err_overrun_d;

    logic          buf_we;
    logic [7:0]    buf_rd_data;
    logic [LW-1:0] last_idx;
    logic          timed;
    logic          drain;

    assign last_idx = len_q - LW'(1);
    assign timed    = (state_q == StLen) || (state_q == StCmd) ||
                      (state_q == StPayload) || (state_q == StCsum);
    assign drain    = (state_q == StDrain);

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (LW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (wr_idx_q),
        .wr_data (bus.in_data),
        .rd_idx  (rd_idx_q),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            len_q         <= '0;
            cmd_q         <= '0;
            csum_q        <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            gap_q         <= '0;
            err_len_q     <= 1'b0;
            err_csum_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cmd_q         <= cmd_d;
            csum_q        <= csum_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            gap_q         <= gap_d;
            err_len_q     <= err_len_d;
            err_csum_q    <= err_csum_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cmd_d         = cmd_q;
        csum_d        = csum_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        gap_d         = gap_q;
        buf_we        = 1'b0;
        err_len_d     = 1'b0;
        err_csum_d    = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;

        // Inter-byte gap; a byte arriving in the limit cycle wins over the timeout.
        if (timed) begin
            if (bus.in_valid) begin
                gap_d = '0;
            end else if (gap_q == GapLimit) begin
                err_timeout_d = 1'b1;
                state_d       = StIdle;
                gap_d         = '0;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && (bus.in_data == SOF_BYTE)) begin
                    state_d = StLen;
                    gap_d   = '0;
                end
            end
            StLen: begin
                if (bus.in_valid) begin
                    if ((bus.in_data == 8'h00) || (32'(bus.in_data) > MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        len_d   = LW'(bus.in_data);
                        csum_d  = bus.in_data;
                        state_d = StCmd;
                    end
                end
            end
            StCmd: begin
                if (bus.in_valid) begin
                    cmd_d    = bus.in_data;
                    csum_d   = csum_q ^ bus.in_data;
                    wr_idx_d = '0;
                    state_d  = StPayload;
                end
            end
            StPayload: begin
                if (bus.in_valid) begin
                    buf_we   = 1'b1;
                    csum_d   = csum_q ^ bus.in_data;
                    wr_idx_d = wr_idx_q + LW'(1);
                    if (wr_idx_q == last_idx) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (bus.in_valid) begin
                    if (bus.in_data == csum_q) begin
                        rd_idx_d = '0;
                        state_d  = StDrain;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StDrain: begin
                // Incoming bytes are dropped; the drain continues untouched.
                if (bus.in_valid) begin
                    err_overrun_d = 1'b1;
                end
                if (bus.out_ready) begin
                    rd_idx_d = rd_idx_q + LW'(1);
                    if (rd_idx_q == last_idx) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stream outputs are forced to zero outside DRAIN so reset leaves every output at 0.
    assign bus.out_valid = drain;
    assign bus.out_data  = drain ? buf_rd_data : 8'h00;
    assign bus.out_last  = drain && (rd_idx_q == last_idx);
    assign bus.out_cmd   = drain ? cmd_q : 8'h00;
    assign bus.out_len   = drain ? len_q : '0;

    assign err_len     = err_len_q;
    assign err_csum    = err_csum_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign busy        = (state_q != StIdle);

endmodule
